// File: rtl/tiny_cpu_pkg.sv
// Shared constants, ALU op encoding and instruction field layout for tiny_cpu.
package tiny_cpu_pkg;

  localparam int unsigned XLEN      = 32;
  localparam int unsigned ROM_WORDS = 16;
  localparam int unsigned ROM_AW    = $clog2(ROM_WORDS);
  localparam int unsigned RESET_PC  = 0;
  localparam int unsigned NREGS     = 32;
  localparam int unsigned RAW       = 5;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLT     = 3'b010;
  localparam logic [2:0] F3_XOR     = 3'b100;
  localparam logic [2:0] F3_OR      = 3'b110;
  localparam logic [2:0] F3_AND     = 3'b111;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  localparam logic [XLEN-1:0] NOP = 32'h0000_0013;

  typedef enum logic [2:0] {
    ALU_ADD,
    ALU_SUB,
    ALU_AND,
    ALU_OR,
    ALU_XOR,
    ALU_SLT,
    ALU_PASS_B
  } alu_op_e;

  // R-type view of an instruction word; other formats reuse the same bit positions
  typedef struct packed {
    logic [6:0]     funct7;
    logic [RAW-1:0] rs2;
    logic [RAW-1:0] rs1;
    logic [2:0]     funct3;
    logic [RAW-1:0] rd;
    logic [6:0]     opcode;
  } instr_t;

endpackage

// File: rtl/tiny_cpu_if.sv
// Status LEDs plus a read-only observation port (PC and one register) for tiny_cpu.
interface tiny_cpu_if
  import tiny_cpu_pkg::*;
();

  logic            led_red;
  logic            led_green;
  logic            led_blue;
  logic [XLEN-1:0] dbg_pc;
  logic [RAW-1:0]  dbg_reg_addr;
  logic [XLEN-1:0] dbg_reg_data_c;

  modport master (
    output led_red,
    output led_green,
    output led_blue,
    output dbg_pc,
    input  dbg_reg_addr,
    output dbg_reg_data_c
  );

  modport slave (
    input  led_red,
    input  led_green,
    input  led_blue,
    input  dbg_pc,
    output dbg_reg_addr,
    input  dbg_reg_data_c
  );

endinterface

// File: rtl/tiny_cpu_alu.sv
// Combinational ALU for tiny_cpu; zero flags a result of 0 for branch compares.
module tiny_cpu_alu
  import tiny_cpu_pkg::*;
(
  input  alu_op_e         alu_op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  output logic [XLEN-1:0] result,
  output logic            zero
);

  always_comb begin
    result = '0;
    unique case (alu_op)
      ALU_ADD:    result = a + b;
      ALU_SUB:    result = a - b;
      ALU_AND:    result = a & b;
      ALU_OR:     result = a | b;
      ALU_XOR:    result = a ^ b;
      ALU_SLT:    result = XLEN'(($signed(a) < $signed(b)) ? 1 : 0);
      ALU_PASS_B: result = b;
      default:    result = '0;
    endcase
  end

  assign zero = (result == '0);

endmodule

// File: rtl/tiny_cpu.sv
// Single-cycle RV32I-subset CPU running a fixed ROM program; reports run/halt/trap on LEDs.
module tiny_cpu
  import tiny_cpu_pkg::*;
(
  input logic        CLK,
  input logic        RST,
  tiny_cpu_if.master bus
);

  // Declaration values give the same state at power-up as after RST
  logic [XLEN-1:0] pc                = XLEN'(RESET_PC);
  logic [XLEN-1:0] regs [NREGS]      = '{default: '0};
  logic            halted            = 1'b0;
  logic            trap              = 1'b0;
  logic            led_red_q         = 1'b1;
  logic            led_green_q       = 1'b1;
  logic            led_blue_q        = 1'b0;

  logic [XLEN-1:0] ir;
  instr_t          instr;
  logic [XLEN-1:0] imm_i, imm_b, imm_j, imm_u;
  logic [XLEN-1:0] rs1_val, rs2_val;
  logic [XLEN-1:0] pc_plus4;

  alu_op_e         alu_op;
  logic [XLEN-1:0] alu_b;
  logic [XLEN-1:0] alu_res;
  logic            alu_zero;

  logic            wb_en;
  logic            is_branch;
  logic            is_jal;
  logic            illegal;
  logic            halt_hit;
  logic            br_taken;
  logic [XLEN-1:0] wb_data;
  logic [XLEN-1:0] pc_nxt;

  // Instruction ROM, indexed by word; PC wraps through the index bits
  always_comb begin
    unique case (pc[ROM_AW+1:2])
      4'h0:    ir = 32'h0050_0093;  // addi x1,x0,5
      4'h1:    ir = 32'h0030_0113;  // addi x2,x0,3
      4'h2:    ir = 32'h0020_81B3;  // add  x3,x1,x2
      4'h3:    ir = 32'h4010_8233;  // sub  x4,x1,x1
      4'h4:    ir = 32'h0011_8293;  // addi x5,x3,1
      4'h5:    ir = 32'h0000_006F;  // jal  x0,0
      default: ir = NOP;
    endcase
  end

  assign instr = instr_t'(ir);

  assign imm_i = {{20{ir[31]}}, ir[31:20]};
  assign imm_b = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
  assign imm_j = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
  assign imm_u = {ir[31:12], 12'b0};

  assign rs1_val  = (instr.rs1 == '0) ? '0 : regs[instr.rs1];
  assign rs2_val  = (instr.rs2 == '0) ? '0 : regs[instr.rs2];
  assign pc_plus4 = pc + XLEN'(4);

  // Decode: ALU control, write enable and legality
  always_comb begin
    alu_op    = ALU_ADD;
    alu_b     = rs2_val;
    wb_en     = 1'b0;
    is_branch = 1'b0;
    is_jal    = 1'b0;
    illegal   = 1'b0;
    unique case (instr.opcode)
      OP_R: begin
        wb_en = 1'b1;
        if (instr.funct3 == F3_ADD_SUB && instr.funct7 == F7_ALT) begin
          alu_op = ALU_SUB;
        end else if (instr.funct7 != F7_BASE) begin
          illegal = 1'b1;
        end else begin
          unique case (instr.funct3)
            F3_ADD_SUB: alu_op = ALU_ADD;
            F3_SLT:     alu_op = ALU_SLT;
            F3_XOR:     alu_op = ALU_XOR;
            F3_OR:      alu_op = ALU_OR;
            F3_AND:     alu_op = ALU_AND;
            default:    illegal = 1'b1;
          endcase
        end
      end
      OP_IMM: begin
        wb_en = 1'b1;
        alu_b = imm_i;
        unique case (instr.funct3)
          F3_ADD_SUB: alu_op = ALU_ADD;
          F3_SLT:     alu_op = ALU_SLT;
          F3_XOR:     alu_op = ALU_XOR;
          F3_OR:      alu_op = ALU_OR;
          F3_AND:     alu_op = ALU_AND;
          default:    illegal = 1'b1;
        endcase
      end
      OP_LUI: begin
        wb_en  = 1'b1;
        alu_op = ALU_PASS_B;
        alu_b  = imm_u;
      end
      OP_BRANCH: begin
        is_branch = 1'b1;
        alu_op    = ALU_SUB;
        if (instr.funct3 != F3_BEQ && instr.funct3 != F3_BNE) begin
          illegal = 1'b1;
        end
      end
      OP_JAL: begin
        wb_en  = 1'b1;
        is_jal = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  tiny_cpu_alu u_alu (
    .alu_op (alu_op),
    .a      (rs1_val),
    .b      (alu_b),
    .result (alu_res),
    .zero   (alu_zero)
  );

  // Next PC and write-back data, kept apart from decode to avoid a loop through the ALU
  always_comb begin
    br_taken = 1'b0;
    halt_hit = 1'b0;
    pc_nxt   = pc_plus4;
    wb_data  = alu_res;
    if (is_branch) begin
      br_taken = (instr.funct3 == F3_BEQ) ? alu_zero : !alu_zero;
      if (br_taken) begin
        pc_nxt = pc + imm_b;
      end
    end
    if (is_jal) begin
      wb_data  = pc_plus4;
      pc_nxt   = pc + imm_j;
      halt_hit = (instr.rd == '0) && (imm_j == '0);
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc          <= XLEN'(RESET_PC);
      for (int i = 0; i < NREGS; i++) begin
        regs[i] <= '0;
      end
      halted      <= 1'b0;
      trap        <= 1'b0;
      led_red_q   <= 1'b1;
      led_green_q <= 1'b1;
      led_blue_q  <= 1'b0;
    end else if (!halted && !trap) begin
      if (illegal) begin
        trap       <= 1'b1;
        led_red_q  <= 1'b0;
        led_blue_q <= 1'b1;
      end else begin
        pc <= pc_nxt;
        if (wb_en && instr.rd != '0) begin
          regs[instr.rd] <= wb_data;
        end
        if (halt_hit) begin
          halted      <= 1'b1;
          led_green_q <= 1'b0;
          led_blue_q  <= 1'b1;
        end
      end
    end
  end

  assign bus.led_red        = led_red_q;
  assign bus.led_green      = led_green_q;
  assign bus.led_blue       = led_blue_q;
  assign bus.dbg_pc         = pc;
  assign bus.dbg_reg_data_c = (bus.dbg_reg_addr == '0) ? '0 : regs[bus.dbg_reg_addr];

endmodule

// File: tb/tb_tiny_cpu.sv
// Directed bench for tiny_cpu: power-up run, reset, halt hold, mid-run reset, ALU vectors.
module tb_tiny_cpu;
  import tiny_cpu_pkg::*;

  typedef struct {
    logic [RAW-1:0]  addr;
    logic [XLEN-1:0] exp;
  } reg_vec_t;

  typedef struct {
    logic [XLEN-1:0] pc;
    logic            green;
    logic            blue;
  } step_vec_t;

  typedef struct {
    alu_op_e         op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] res;
    logic            zero;
  } alu_vec_t;

  logic CLK;
  logic RST;
  int   total;
  int   bad;

  tiny_cpu_if bus ();

  tiny_cpu dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  alu_op_e         u_op;
  logic [XLEN-1:0] u_a, u_b, u_res;
  logic            u_zero;

  tiny_cpu_alu u_alu (
    .alu_op (u_op),
    .a      (u_a),
    .b      (u_b),
    .result (u_res),
    .zero   (u_zero)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  reg_vec_t  final_regs [8];
  step_vec_t run_steps  [6];
  alu_vec_t  alu_vecs   [8];

  task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    @(negedge CLK);
  endtask

  task automatic read_reg(input logic [RAW-1:0] addr, output logic [XLEN-1:0] data);
    bus.dbg_reg_addr = addr;
    #1;
    data = bus.dbg_reg_data_c;
  endtask

  // Register sweep; only used while the CPU state is stable (halted or held in reset)
  task automatic check_final(input string tag);
    logic [XLEN-1:0] d;
    for (int i = 0; i < 8; i++) begin
      read_reg(final_regs[i].addr, d);
      check($sformatf("%s_x%0d", tag, final_regs[i].addr), d, final_regs[i].exp);
    end
    check({tag, "_pc"}, bus.dbg_pc, 32'h14);
    check({tag, "_green"}, XLEN'(bus.led_green), 32'h0);
    check({tag, "_blue"}, XLEN'(bus.led_blue), 32'h1);
    check({tag, "_red"}, XLEN'(bus.led_red), 32'h1);
  endtask

  task automatic check_cleared(input string tag, input int last);
    logic [XLEN-1:0] d;
    check({tag, "_pc"}, bus.dbg_pc, 32'h0);
    check({tag, "_blue"}, XLEN'(bus.led_blue), 32'h0);
    check({tag, "_green"}, XLEN'(bus.led_green), 32'h1);
    check({tag, "_red"}, XLEN'(bus.led_red), 32'h1);
    for (int i = 1; i <= last; i++) begin
      read_reg(RAW'(i), d);
      check($sformatf("%s_x%0d", tag, i), d, 32'h0);
    end
  endtask

  // Bounded wait for the halt LED; an expired bound is reported as a failed check
  task automatic wait_halt(input string tag, input int limit);
    int n;
    n = 0;
    while (bus.led_green !== 1'b0 && n < limit) begin
      step(1);
      n++;
    end
    check({tag, "_halt_seen"}, XLEN'(bus.led_green), 32'h0);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    RST   = 1'b0;
    bus.dbg_reg_addr = '0;
    u_op = ALU_ADD;
    u_a  = '0;
    u_b  = '0;

    final_regs[0] = '{5'd1,  32'd5};
    final_regs[1] = '{5'd2,  32'd3};
    final_regs[2] = '{5'd3,  32'd8};
    final_regs[3] = '{5'd4,  32'd0};
    final_regs[4] = '{5'd5,  32'd9};
    final_regs[5] = '{5'd6,  32'd0};
    final_regs[6] = '{5'd0,  32'd0};
    final_regs[7] = '{5'd31, 32'd0};

    run_steps[0] = '{32'h04, 1'b1, 1'b0};
    run_steps[1] = '{32'h08, 1'b1, 1'b0};
    run_steps[2] = '{32'h0C, 1'b1, 1'b0};
    run_steps[3] = '{32'h10, 1'b1, 1'b0};
    run_steps[4] = '{32'h14, 1'b1, 1'b0};
    run_steps[5] = '{32'h14, 1'b0, 1'b1};

    alu_vecs[0] = '{ALU_ADD,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000, 1'b1};
    alu_vecs[1] = '{ALU_SUB,    32'h0000_0003, 32'h0000_0005, 32'hFFFF_FFFE, 1'b0};
    alu_vecs[2] = '{ALU_SLT,    32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0001, 1'b0};
    alu_vecs[3] = '{ALU_XOR,    32'h0000_00F0, 32'h0000_00FF, 32'h0000_000F, 1'b0};
    alu_vecs[4] = '{ALU_SLT,    32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1};
    alu_vecs[5] = '{ALU_AND,    32'h0000_00F0, 32'h0000_003C, 32'h0000_0030, 1'b0};
    alu_vecs[6] = '{ALU_OR,     32'h0000_00F0, 32'h0000_000F, 32'h0000_00FF, 1'b0};
    alu_vecs[7] = '{ALU_PASS_B, 32'h1234_5678, 32'hABCD_E000, 32'hABCD_E000, 1'b0};

    // Power-up without reset: initial LEDs, then the program halts within 8 cycles
    #1;
    check("pwr_blue", XLEN'(bus.led_blue), 32'h0);
    check("pwr_green", XLEN'(bus.led_green), 32'h1);
    check("pwr_pc", bus.dbg_pc, 32'h0);
    @(negedge CLK);
    wait_halt("pwr", 8);
    check_final("pwr");

    // Reset held for two cycles clears everything
    @(negedge CLK);
    RST = 1'b1;
    step(2);
    check_cleared("rst", 31);
    @(negedge CLK);
    RST = 1'b0;

    // One instruction per edge, halt on the sixth
    for (int i = 0; i < 6; i++) begin
      step(1);
      check($sformatf("run%0d_pc", i + 1), bus.dbg_pc, run_steps[i].pc);
      check($sformatf("run%0d_green", i + 1), XLEN'(bus.led_green), XLEN'(run_steps[i].green));
      check($sformatf("run%0d_blue", i + 1), XLEN'(bus.led_blue), XLEN'(run_steps[i].blue));
    end
    check_final("run");

    // Halted state holds for 10 more cycles
    @(negedge CLK);
    step(10);
    check_final("hold");

    // Reset mid-program restarts from the beginning
    @(negedge CLK);
    RST = 1'b1;
    step(1);
    @(negedge CLK);
    RST = 1'b0;
    step(3);
    check("mid_pc3", bus.dbg_pc, 32'h0C);
    RST = 1'b1;
    step(1);
    check_cleared("mid_rst", 5);
    @(negedge CLK);
    RST = 1'b0;
    wait_halt("rerun", 8);
    check_final("rerun");

    // ALU unit vectors
    for (int i = 0; i < 8; i++) begin
      u_op = alu_vecs[i].op;
      u_a  = alu_vecs[i].a;
      u_b  = alu_vecs[i].b;
      #1;
      check($sformatf("alu%0d_res", i), u_res, alu_vecs[i].res);
      check($sformatf("alu%0d_zero", i), XLEN'(u_zero), XLEN'(alu_vecs[i].zero));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
